uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50_000_000/115_200, meaning clk cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter BITS_N, default 8, meaning data bits per frame.
REQ-003 SHALL have parameter PARITY_TYPE, default 2, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port uart_in, input, 1, meaning the asynchronous serial line (idle high).
REQ-007 SHALL have port data_rx, output, BITS_N, meaning the received data word.
REQ-008 SHALL have port valid, output, 1, meaning data_rx and the error flags hold an unconsumed frame.
REQ-009 SHALL have port ready, input, 1, meaning the consumer accepts the frame when valid && ready.
REQ-010 SHALL have port parity_err, output, 1, meaning the parity of the held frame mismatched.
REQ-011 SHALL have port framing_err, output, 1, meaning the stop bit of the held frame was sampled low.
REQ-012 SHALL have port overrun, output, 1, meaning a frame was dropped because valid was still high.

Function
REQ-013 SHALL pass uart_in through a two-flop synchronizer (both reset to 1); all FSM decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY, STOP_BIT.
REQ-015 IDLE: on synchronized line = 0, clear counter and bit index, go to START_BIT.
REQ-016 START_BIT: after CLKS_PER_BIT/2 cycles (integer division), sample; line 1 -> IDLE (false start, no output change), line 0 -> clear counter, go to DATA_BITS.
REQ-017 DATA_BITS: sample every CLKS_PER_BIT cycles (mid-bit); store bits LSB-first at index 0..BITS_N-1; after bit BITS_N-1 go to PARITY if PARITY_TYPE != 0, else STOP_BIT.
REQ-018 PARITY: sample after CLKS_PER_BIT cycles; expected bit = XOR of data (type 2) or XNOR of data (type 1); mismatch sets the internal parity error; go to STOP_BIT.
REQ-019 STOP_BIT: sample after CLKS_PER_BIT cycles; sample 0 sets the internal framing error; go to IDLE in the same cycle as the sample, with no wait for the bit end.
REQ-020 On the stop-bit sample cycle, if valid is 0 or (valid && ready), SHALL on the next edge load data_rx, parity_err and framing_err and set valid = 1.
REQ-021 If valid && !ready on the stop-bit sample cycle, SHALL drop the new frame, keep the held data and flags unchanged, and set overrun = 1.
REQ-022 valid SHALL clear one cycle after valid && ready, unless a new frame loads in that same cycle, in which case valid stays 1.
REQ-023 overrun SHALL be sticky and clear on the next valid && ready handshake.
REQ-024 With PARITY_TYPE = 0, parity_err SHALL always be 0.
REQ-025 Latency: valid SHALL rise exactly one clk after the stop-bit sample.
REQ-026 The counter SHALL be wide enough for CLKS_PER_BIT-1, and the bit index wide enough for BITS_N-1, with no wrap inside a frame.

Reset
REQ-027 On rst = 1, SHALL immediately force state IDLE, counters 0, synchronizer flops 1, data_rx 0, and valid, parity_err, framing_err and overrun 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only on a new falling edge.

Verification (CLKS_PER_BIT=5, BITS_N=8, PARITY_TYPE=2, ready=1 unless stated)
REQ-029 Frame 0xA5, parity 0, stop 1 -> data_rx=0xA5, valid pulses 1 cycle, parity_err=0, framing_err=0.
REQ-030 Frame 0x07 with parity bit 0 (expected 1) -> valid, data_rx=0x07, parity_err=1.
REQ-031 Frame 0x3C with stop bit 0 -> valid, data_rx=0x3C, framing_err=1; next correct frame 0x11 receives cleanly.
REQ-032 Line low for 2 cycles then high -> no valid, FSM back in IDLE.
REQ-033 ready=0; frames 0x12 then 0x34 -> data_rx stays 0x12, overrun=1; ready=1 -> valid and overrun clear.
REQ-034 rst pulse during the 4th data bit of 0xFF, then frame 0x5A -> only 0x5A is delivered, all flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, optional parity,
// valid/ready output holding register with sticky overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    input  logic              ready,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    output logic              parity_err,
    output logic              framing_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY,
        STOP_BIT
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BITS_N-1:0]  shift_q, shift_d;
    logic               perr_int_q, perr_int_d;
    logic [BITS_N-1:0]  data_rx_q, data_rx_d;
    logic               valid_q, valid_d;
    logic               parity_err_q, parity_err_d;
    logic               framing_err_q, framing_err_d;
    logic               overrun_q, overrun_d;
    logic               frame_done;
    logic               stop_low;
    logic               rx;
    logic               exp_parity;

    assign rx         = sync2_q;
    assign exp_parity = (PARITY_TYPE == 1) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_int_d = perr_int_q;
        frame_done = 1'b0;
        stop_low   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d      = '0;
                        perr_int_d = 1'b0;
                        state_d    = DATA_BITS;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA_BITS: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_TYPE != 0) ? PARITY : STOP_BIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d      = '0;
                    perr_int_d = rx ^ exp_parity;
                    state_d    = STOP_BIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP_BIT: begin
                // Return to IDLE at the mid-bit sample so the next start edge is not missed.
                if (cnt_q == CNT_FULL) begin
                    cnt_d      = '0;
                    frame_done = 1'b1;
                    stop_low   = ~rx;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_rx_d     = data_rx_q;
        valid_d       = valid_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
        if (valid_q && ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (frame_done) begin
            if (!valid_q || ready) begin
                data_rx_d     = shift_q;
                parity_err_d  = (PARITY_TYPE != 0) && perr_int_q;
                framing_err_d = stop_low;
                valid_d       = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            perr_int_q    <= 1'b0;
            data_rx_q     <= '0;
            valid_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= uart_in;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            perr_int_q    <= perr_int_d;
            data_rx_q     <= data_rx_d;
            valid_q       <= valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_rx     = data_rx_q;
    assign valid       = valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are built from data bytes and
// compared with the frames handed over on valid && ready.
module tb_uart_rx;

    localparam int C = 5;

    logic       clk;
    logic       rst;
    logic       uart_in;
    logic       ready;
    logic [7:0] data_rx;
    logic       valid;
    logic       parity_err;
    logic       framing_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_hi = 0;
    logic [9:0] got_q[$];

    uart_rx #(
        .CLKS_PER_BIT(C),
        .BITS_N(8),
        .PARITY_TYPE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_in(uart_in),
        .data_rx(data_rx),
        .valid(valid),
        .ready(ready),
        .parity_err(parity_err),
        .framing_err(framing_err),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collects every handed-over frame as {data, parity_err, framing_err}.
    always @(negedge clk) begin
        if (valid) valid_hi++;
        if (valid && ready) got_q.push_back({data_rx, parity_err, framing_err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_in = b;
        repeat (C) tick();
    endtask

    // Even parity: the correct parity bit is the XOR of the data bits.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ par_flip);
        drive_bit(stop_v);
        drive_bit(1'b1);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_in = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({valid, parity_err, framing_err, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 0000", {valid, parity_err, framing_err, overrun});
        end
        n_checks++;
        if (data_rx !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 00", data_rx);
        end
        rst = 1'b0;
        repeat (2 * C) tick();
    endtask

    task automatic test_good_frame();
        int v0;
        logic [9:0] e;
        got_q.delete();
        v0 = valid_hi;
        send_frame(8'hA5, 1'b0, 1'b1);
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'hA5, 2'b00}) begin
            n_fail++;
            $display("FAIL good_frame: got %h, want %h", e, {8'hA5, 2'b00});
        end
        n_checks++;
        if (valid_hi - v0 !== 1) begin
            n_fail++;
            $display("FAIL valid_pulse_width: got %0d cycles, want 1", valid_hi - v0);
        end
    endtask

    task automatic test_parity_error();
        logic [9:0] e;
        got_q.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'h07, 2'b10}) begin
            n_fail++;
            $display("FAIL parity_error: got %h, want %h", e, {8'h07, 2'b10});
        end
    endtask

    task automatic test_framing_error();
        logic [9:0] e;
        got_q.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'h3C, 2'b01}) begin
            n_fail++;
            $display("FAIL framing_error: got %h, want %h", e, {8'h3C, 2'b01});
        end
        send_frame(8'h11, 1'b0, 1'b1);
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'h11, 2'b00}) begin
            n_fail++;
            $display("FAIL after_framing: got %h, want %h", e, {8'h11, 2'b00});
        end
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL framing_spurious: got %0d extra frames, want 0", got_q.size());
        end
    endtask

    task automatic test_false_start();
        logic [9:0] e;
        got_q.delete();
        uart_in = 1'b0;
        repeat (2) tick();
        uart_in = 1'b1;
        repeat (3 * 12 * C) tick();
        n_checks++;
        if (got_q.size() !== 0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL false_start: got %0d frames valid=%b, want 0 frames valid=0", got_q.size(), valid);
        end
        send_frame(8'h6E, 1'b0, 1'b1);
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'h6E, 2'b00}) begin
            n_fail++;
            $display("FAIL after_false_start: got %h, want %h", e, {8'h6E, 2'b00});
        end
    endtask

    task automatic test_overrun();
        logic [9:0] e;
        got_q.delete();
        ready = 1'b0;
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1);
        n_checks++;
        if ({valid, overrun, data_rx} !== {1'b1, 1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid=%b overrun=%b data=%h, want 1 1 12", valid, overrun, data_rx);
        end
        n_checks++;
        if ({parity_err, framing_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL overrun_flags: got %b, want 00", {parity_err, framing_err});
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if ({valid, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL overrun_clear: got valid=%b overrun=%b, want 0 0", valid, overrun);
        end
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'h12, 2'b00} || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL overrun_frame: got %h (+%0d more), want %h only", e, got_q.size(), {8'h12, 2'b00});
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] e;
        got_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        uart_in = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valid, overrun, parity_err, framing_err, data_rx} !== 12'h000) begin
            n_fail++;
            $display("FAIL midframe_reset: got valid=%b ovr=%b pe=%b fe=%b data=%h, want all 0",
                     valid, overrun, parity_err, framing_err, data_rx);
        end
        tick();
        rst = 1'b0;
        repeat (2 * C) tick();
        send_frame(8'h5A, 1'b0, 1'b1);
        e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_checks++;
        if (e !== {8'h5A, 2'b00} || got_q.size() !== 0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got %h (+%0d more) ovr=%b, want %h only ovr=0",
                     e, got_q.size(), overrun, {8'h5A, 2'b00});
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       pf;
        logic       sv;
        logic [9:0] e;
        logic [9:0] want;
        for (int n = 0; n < 24; n++) begin
            got_q.delete();
            d  = 8'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 4) != 0);
            want = {d, pf, ~sv};
            send_frame(d, pf, sv);
            repeat ($urandom_range(0, 2 * C)) tick();
            e = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_checks++;
            if (e !== want || got_q.size() !== 0) begin
                n_fail++;
                $display("FAIL random_frame_%0d: got %h (+%0d more), want %h", n, e, got_q.size(), want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_false_start();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
